mem_req_ctrl: RTL and testbench
===============================

// Module: mem_req_ctrl
// PURPOSE
//  Memory request controller between execute (mem FU) and the data-side SRAM-like bus.
//  Grants issue-slot credits via mem_ctrl_intf (mem_issued in, wait_mem out) and queues
//  mem ops arriving from ereg. Drives bus requests in order, formats store data and
//  load-extends read data. Returns one completion per op to commit (mem_commit path).
// PARAMETERS
//  DEPTH   4  max ops in flight (reserved + queued + on bus + awaiting data_ok); power of 2
//  PREG_W  6  physical register / ROB id width (matches preg_addr_t)
// PORTS
//  clk            in   1       clock
//  resetn         in   1       synchronous reset, active low
//  mem_issued     in   1       issue selected a mem op this cycle; reserve one credit
//  wait_mem       out  1       no free credit; issue must not select a mem op
//  flush          in   1       branch mispredict / exception flush
//  in_valid       in   1       mem op from execute (arrives after its mem_issued)
//  in_wr          in   1       1 = store, 0 = load
//  in_size        in   2       0 byte, 1 half, 2 word
//  in_unsigned    in   1       zero-extend load (lbu/lhu)
//  in_addr        in   32      effective address
//  in_wdata       in   32      store data, unaligned in low bits
//  in_preg        in   PREG_W  destination preg / ROB id
//  data_req       out  1       bus request
//  data_wr        out  1       bus write
//  data_size      out  2       bus size
//  data_addr      out  32      bus address
//  data_wdata     out  32      lane-replicated store data
//  data_addr_ok   in   1       request accepted
//  data_data_ok   in   1       response, in request order
//  data_rdata     in   32      read data
//  cm_valid       out  1       completion to commit, 1-cycle pulse
//  cm_preg        out  PREG_W  completing op id
//  cm_data        out  32      extended load data; 0 for stores
//  cm_adel/cm_ades out 1 each  address-error load/store (only with macro)
// BEHAVIOUR
//  Reset: all outputs 0 except wait_mem=0; free credits=DEPTH; both queues empty.
//  Credits: free = DEPTH - reserved - reqQ_cnt - pendQ_cnt; wait_mem = (free==0), comb from regs.
//   mem_issued: reserved++. in_valid: reserved--, op pushed to reqQ. data_ok pops pendQ.
//   All same-cycle updates net out (e.g. reserve + data_ok at full = still full).
//  in_valid with reserved==0 is a protocol violation (assertion, no state change).
//  Bus: data_req = reqQ non-empty; fields from reqQ head, stable while data_req && !addr_ok.
//   addr_ok: head moves reqQ->pendQ; next head may be presented the following cycle.
//   Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
//  data_ok: pop pendQ head; register cm_valid/cm_preg/cm_data next cycle (latency 1).
//   Load extract: byte rdata[8*addr[1:0]+:8], half rdata[16*addr[1]+:16]; sign- or zero-extend.
//   data_ok with empty pendQ: ignored, assertion fires.
//  Flush (highest priority, single cycle):
//   reserved=0; in_valid and mem_issued that cycle dropped.
//   reqQ entries not yet on bus discarded.
//   Head presented with data_req=1 and no addr_ok: stays on bus, moved to pendQ as killed on addr_ok.
//   pendQ entries marked killed; their data_ok consumed, credit freed, no cm_valid.
//   cm_valid of data_ok cycle coincident with flush is suppressed.
//  Wrap: queue pointers log2(DEPTH)+1 bits, natural wrap; full/empty via MSB compare.
//  Reset mid-transfer: queues cleared; stale data_ok after reset ignored (pendQ empty).
// CONFIGURATION
//  MEM_REQ_CTRL_ADDR_CHECK_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0
//   never reaches the bus. Op completes next cycle via cm_valid with cm_adel (load) or
//   cm_ades (store)=1, cm_data=0. Alignment-completion and data_ok-completion in the
//   same cycle: data_ok first, alignment completion delayed one cycle.
//  Undefined: no check; misaligned ops issued as-is; cm_adel/cm_ades tied 0.
// TESTING
//  Load byte signed addr=0x..03, rdata=0x80112233, data_ok 3 cycles later -> cm_data=0xFFFFFF80, cm_preg match.
//  Four mem_issued back-to-back, DEPTH=4, addr_ok held 0 -> wait_mem=1 after 4th; one data_ok -> wait_mem=0.
//  Store half wdata=0x1234ABCD addr=0x..02 -> data_wdata=0xABCDABCD, data_size=1, cm_data=0.
//  Flush with 1 req on bus unaccepted + 2 pending -> addr_ok later, 3 data_ok, zero cm_valid, free back to DEPTH.
//  mem_issued and data_ok same cycle at full -> wait_mem stays 1, count unchanged.
//  Macro on: load word addr=0x1002 -> no data_req, cm_valid next cycle with cm_adel=1.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - in-order data-bus request controller with issue credits and load extension
// Optional misaligned-address trap enabled by defining MEM_REQ_CTRL_ADDR_CHECK_EN.
module mem_req_ctrl #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_issued,
    output logic              wait_mem,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_wr,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [PREG_W-1:0] in_preg,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              cm_valid,
    output logic [PREG_W-1:0] cm_preg,
    output logic [31:0]       cm_data,
    output logic              cm_adel,
    output logic              cm_ades
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

    logic              req_wr_q    [DEPTH];
    logic [1:0]        req_size_q  [DEPTH];
    logic              req_uns_q   [DEPTH];
    logic [31:0]       req_addr_q  [DEPTH];
    logic [31:0]       req_wdata_q [DEPTH];
    logic [PREG_W-1:0] req_preg_q  [DEPTH];
    logic [PTR_W-1:0]  req_wptr_q, req_wptr_d, req_rptr_q, req_rptr_d;
    logic              head_kill_q, head_kill_d;

    logic [PREG_W-1:0] pend_preg_q [DEPTH];
    logic              pend_wr_q   [DEPTH];
    logic [1:0]        pend_size_q [DEPTH];
    logic              pend_uns_q  [DEPTH];
    logic [1:0]        pend_off_q  [DEPTH];
    logic              pend_kill_q [DEPTH];
    logic [PTR_W-1:0]  pend_wptr_q, pend_wptr_d, pend_rptr_q, pend_rptr_d;

    logic [PTR_W-1:0]  reserved_q, reserved_d;
    logic              cm_valid_q, cm_valid_d, cm_adel_q, cm_adel_d, cm_ades_q, cm_ades_d;
    logic [PREG_W-1:0] cm_preg_q, cm_preg_d;
    logic [31:0]       cm_data_q, cm_data_d;

    logic [IDX_W-1:0]  rh, ph;
    logic [PTR_W-1:0]  req_cnt, pend_cnt, free_cnt;
    logic              req_empty, pend_empty, req_accept, pend_pop;
    logic              in_ok, in_misal, req_push, issue_ok, dok_cm;
    logic [31:0]       load_data, store_data;
    logic [7:0]        lane8;
    logic [15:0]       lane16;
    logic [PTR_W-1:0]  al_cnt;
    logic              al_empty, al_head_wr;
    logic [PREG_W-1:0] al_head_preg;

    assign rh         = req_rptr_q[IDX_W-1:0];
    assign ph         = pend_rptr_q[IDX_W-1:0];
    assign req_cnt    = req_wptr_q - req_rptr_q;
    assign pend_cnt   = pend_wptr_q - pend_rptr_q;
    assign req_empty  = (req_wptr_q == req_rptr_q);
    assign pend_empty = (pend_wptr_q == pend_rptr_q);
    assign free_cnt   = DEPTH_C - reserved_q - req_cnt - pend_cnt - al_cnt;
    assign wait_mem   = (free_cnt == '0);

    assign req_accept = !req_empty && data_addr_ok;
    assign pend_pop   = data_data_ok && !pend_empty;
    assign in_ok      = in_valid && !flush && (reserved_q != '0);
    assign req_push   = in_ok && !in_misal;
    assign issue_ok   = mem_issued && !flush && ((free_cnt != '0) || pend_pop);
    assign dok_cm     = pend_pop && !pend_kill_q[ph] && !flush;

`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
    // Trapped ops wait here only when a data_ok completion owns the cm slot.
    logic [PREG_W-1:0] al_preg_q [DEPTH];
    logic              al_wr_q   [DEPTH];
    logic [PTR_W-1:0]  al_wptr_q, al_rptr_q;
    logic              al_push, al_pop;

    assign al_cnt       = al_wptr_q - al_rptr_q;
    assign al_empty     = (al_cnt == '0);
    assign al_head_preg = al_preg_q[al_rptr_q[IDX_W-1:0]];
    assign al_head_wr   = al_wr_q[al_rptr_q[IDX_W-1:0]];
    assign in_misal     = in_ok && (((in_size == 2'd1) && in_addr[0]) ||
                                    (in_size[1] && (in_addr[1:0] != 2'b00)));
    assign al_pop       = !dok_cm && !flush && !al_empty;
    assign al_push      = in_misal && (dok_cm || !al_empty);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            al_wptr_q <= '0;
            al_rptr_q <= '0;
        end else if (flush) begin
            al_rptr_q <= al_wptr_q;
        end else begin
            if (al_push) begin
                al_preg_q[al_wptr_q[IDX_W-1:0]] <= in_preg;
                al_wr_q[al_wptr_q[IDX_W-1:0]]   <= in_wr;
                al_wptr_q                       <= al_wptr_q + ONE;
            end
            if (al_pop) begin
                al_rptr_q <= al_rptr_q + ONE;
            end
        end
    end
`else
    assign al_cnt       = '0;
    assign al_empty     = 1'b1;
    assign al_head_preg = '0;
    assign al_head_wr   = 1'b0;
    assign in_misal     = 1'b0;
`endif

    always_comb begin
        case (req_size_q[rh])
            2'd0:    store_data = {4{req_wdata_q[rh][7:0]}};
            2'd1:    store_data = {2{req_wdata_q[rh][15:0]}};
            default: store_data = req_wdata_q[rh];
        endcase
    end

    assign data_req   = !req_empty;
    assign data_wr    = data_req ? req_wr_q[rh]   : 1'b0;
    assign data_size  = data_req ? req_size_q[rh] : 2'd0;
    assign data_addr  = data_req ? req_addr_q[rh] : 32'd0;
    assign data_wdata = data_req ? store_data     : 32'd0;

    always_comb begin
        lane8  = data_rdata[{pend_off_q[ph], 3'b000} +: 8];
        lane16 = data_rdata[{pend_off_q[ph][1], 4'b0000} +: 16];
        case (pend_size_q[ph])
            2'd0:    load_data = {{24{~pend_uns_q[ph] & lane8[7]}}, lane8};
            2'd1:    load_data = {{16{~pend_uns_q[ph] & lane16[15]}}, lane16};
            default: load_data = data_rdata;
        endcase
    end

    always_comb begin
        reserved_d  = flush ? '0 : reserved_q + PTR_W'(issue_ok) - PTR_W'(in_ok);
        req_rptr_d  = req_rptr_q + PTR_W'(req_accept);
        pend_wptr_d = pend_wptr_q + PTR_W'(req_accept);
        pend_rptr_d = pend_rptr_q + PTR_W'(pend_pop);
        // On flush only the head already presented on the bus survives.
        if (flush) begin
            req_wptr_d = req_empty ? req_wptr_q : req_rptr_q + ONE;
        end else begin
            req_wptr_d = req_wptr_q + PTR_W'(req_push);
        end
        if (req_accept) begin
            head_kill_d = 1'b0;
        end else if (flush && !req_empty) begin
            head_kill_d = 1'b1;
        end else begin
            head_kill_d = head_kill_q;
        end
    end

    always_comb begin
        cm_valid_d = 1'b0;
        cm_preg_d  = cm_preg_q;
        cm_data_d  = cm_data_q;
        cm_adel_d  = 1'b0;
        cm_ades_d  = 1'b0;
        if (dok_cm) begin
            cm_valid_d = 1'b1;
            cm_preg_d  = pend_preg_q[ph];
            cm_data_d  = pend_wr_q[ph] ? 32'd0 : load_data;
        end else if (!flush && !al_empty) begin
            cm_valid_d = 1'b1;
            cm_preg_d  = al_head_preg;
            cm_data_d  = 32'd0;
            cm_adel_d  = !al_head_wr;
            cm_ades_d  = al_head_wr;
        end else if (in_misal) begin
            cm_valid_d = 1'b1;
            cm_preg_d  = in_preg;
            cm_data_d  = 32'd0;
            cm_adel_d  = !in_wr;
            cm_ades_d  = in_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            reserved_q  <= '0;
            req_wptr_q  <= '0;
            req_rptr_q  <= '0;
            pend_wptr_q <= '0;
            pend_rptr_q <= '0;
            head_kill_q <= 1'b0;
            cm_valid_q  <= 1'b0;
            cm_preg_q   <= '0;
            cm_data_q   <= '0;
            cm_adel_q   <= 1'b0;
            cm_ades_q   <= 1'b0;
        end else begin
            reserved_q  <= reserved_d;
            req_wptr_q  <= req_wptr_d;
            req_rptr_q  <= req_rptr_d;
            pend_wptr_q <= pend_wptr_d;
            pend_rptr_q <= pend_rptr_d;
            head_kill_q <= head_kill_d;
            cm_valid_q  <= cm_valid_d;
            cm_preg_q   <= cm_preg_d;
            cm_data_q   <= cm_data_d;
            cm_adel_q   <= cm_adel_d;
            cm_ades_q   <= cm_ades_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_push) begin
            req_wr_q[req_wptr_q[IDX_W-1:0]]    <= in_wr;
            req_size_q[req_wptr_q[IDX_W-1:0]]  <= in_size;
            req_uns_q[req_wptr_q[IDX_W-1:0]]   <= in_unsigned;
            req_addr_q[req_wptr_q[IDX_W-1:0]]  <= in_addr;
            req_wdata_q[req_wptr_q[IDX_W-1:0]] <= in_wdata;
            req_preg_q[req_wptr_q[IDX_W-1:0]]  <= in_preg;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                pend_kill_q[i] <= 1'b1;
            end
        end
        if (req_accept) begin
            pend_preg_q[pend_wptr_q[IDX_W-1:0]] <= req_preg_q[rh];
            pend_wr_q[pend_wptr_q[IDX_W-1:0]]   <= req_wr_q[rh];
            pend_size_q[pend_wptr_q[IDX_W-1:0]] <= req_size_q[rh];
            pend_uns_q[pend_wptr_q[IDX_W-1:0]]  <= req_uns_q[rh];
            pend_off_q[pend_wptr_q[IDX_W-1:0]]  <= req_addr_q[rh][1:0];
            pend_kill_q[pend_wptr_q[IDX_W-1:0]] <= head_kill_q | flush;
        end
    end

    assign cm_valid = cm_valid_q;
    assign cm_preg  = cm_preg_q;
    assign cm_data  = cm_data_q;
    assign cm_adel  = cm_adel_q;
    assign cm_ades  = cm_ades_q;

`ifndef SYNTHESIS
    a_in_no_credit: assert property (@(posedge clk) disable iff (!resetn)
        !(in_valid && !flush && (reserved_q == '0)));
    a_dok_empty: assert property (@(posedge clk) disable iff (!resetn)
        !(data_data_ok && pend_empty));
`endif
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed and randomized checks of mem_req_ctrl against a queue-level model
module tb_mem_req_ctrl;
    localparam int DEPTH  = 4;
    localparam int PREG_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn, mem_issued, flush, in_valid, in_wr, in_unsigned;
    logic [1:0]        in_size;
    logic [31:0]       in_addr, in_wdata, data_rdata;
    logic [PREG_W-1:0] in_preg;
    logic              data_addr_ok, data_data_ok;
    logic              wait_mem, data_req, data_wr, cm_valid, cm_adel, cm_ades;
    logic [1:0]        data_size;
    logic [31:0]       data_addr, data_wdata, cm_data;
    logic [PREG_W-1:0] cm_preg;

    mem_req_ctrl #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
        .clk(clk), .resetn(resetn), .mem_issued(mem_issued), .wait_mem(wait_mem),
        .flush(flush), .in_valid(in_valid), .in_wr(in_wr), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_preg(in_preg),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .cm_valid(cm_valid), .cm_preg(cm_preg), .cm_data(cm_data),
        .cm_adel(cm_adel), .cm_ades(cm_ades)
    );

    typedef struct {
        logic              wr;
        logic [1:0]        size;
        logic              uns;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [PREG_W-1:0] preg;
        logic              killed;
    } op_t;
    typedef struct {
        logic [PREG_W-1:0] preg;
        logic              wr;
    } al_t;

    op_t m_req[$];
    op_t m_pend[$];
    al_t m_al[$];
    int  m_res;
    logic              e_cm_valid, e_adel, e_ades;
    logic [PREG_W-1:0] e_cm_preg;
    logic [31:0]       e_cm_data;
    int checks, errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_free();
        return DEPTH - m_res - m_req.size() - m_pend.size() - m_al.size();
    endfunction

    function automatic bit misal(input logic [1:0] s, input logic [31:0] a);
`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
        return ((s == 2'd1) && (a % 2 != 0)) || ((s >= 2'd2) && (a % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] repl(input logic [1:0] s, input logic [31:0] w);
        if (s == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (s == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ext(input op_t o, input logic [31:0] rd);
        logic [31:0] v;
        if (o.wr) return 32'd0;
        if (o.size == 2'd0) begin
            v = (rd >> (8 * o.addr[1:0])) & 32'hFF;
            if (!o.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (o.size == 2'd1) begin
            v = (rd >> (16 * o.addr[1])) & 32'hFFFF;
            if (!o.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic model_step();
        op_t h, e;
        al_t a;
        bit  dok_done, popped, accepted;
        int  free0;
        free0 = m_free();
        e_cm_valid = 1'b0; e_adel = 1'b0; e_ades = 1'b0;
        dok_done = 0; popped = 0; accepted = 0;
        if (!resetn) begin
            m_req.delete(); m_pend.delete(); m_al.delete(); m_res = 0;
            e_cm_preg = '0; e_cm_data = '0;
            return;
        end
        if (data_data_ok && m_pend.size() > 0) begin
            e = m_pend.pop_front();
            popped = 1;
            if (!e.killed && !flush) begin
                e_cm_valid = 1'b1; e_cm_preg = e.preg; e_cm_data = ext(e, data_rdata);
                dok_done = 1;
            end
        end
        if (data_addr_ok && m_req.size() > 0) begin
            h = m_req.pop_front();
            h.killed = h.killed | flush;
            m_pend.push_back(h);
            accepted = 1;
        end
        if (flush) begin
            m_res = 0;
            m_al.delete();
            if (!accepted && m_req.size() > 0) begin
                h = m_req[0]; h.killed = 1'b1;
                m_req.delete(); m_req.push_back(h);
            end else begin
                m_req.delete();
            end
            foreach (m_pend[i]) m_pend[i].killed = 1'b1;
        end else begin
            if (in_valid && m_res > 0) begin
                m_res--;
                if (misal(in_size, in_addr)) begin
                    a.preg = in_preg; a.wr = in_wr;
                    m_al.push_back(a);
                end else begin
                    h.wr = in_wr; h.size = in_size; h.uns = in_unsigned; h.addr = in_addr;
                    h.wdata = in_wdata; h.preg = in_preg; h.killed = 1'b0;
                    m_req.push_back(h);
                end
            end
            if (!dok_done && m_al.size() > 0) begin
                a = m_al.pop_front();
                e_cm_valid = 1'b1; e_cm_preg = a.preg; e_cm_data = 32'd0;
                e_adel = !a.wr; e_ades = a.wr;
            end
            if (mem_issued && (free0 > 0 || popped)) m_res++;
        end
    endtask

    task automatic check_outputs();
        bit ereq;
        ereq = (m_req.size() > 0);
        chk("wait_mem", wait_mem, m_free() == 0);
        chk("data_req", data_req, ereq);
        if (ereq) begin
            chk("data_addr", data_addr, m_req[0].addr);
            chk("data_wr", data_wr, m_req[0].wr);
            chk("data_size", data_size, m_req[0].size);
            chk("data_wdata", data_wdata, repl(m_req[0].size, m_req[0].wdata));
        end
        chk("cm_valid", cm_valid, e_cm_valid);
        if (e_cm_valid) begin
            chk("cm_preg", cm_preg, e_cm_preg);
            chk("cm_data", cm_data, e_cm_data);
            chk("cm_adel", cm_adel, e_adel);
            chk("cm_ades", cm_ades, e_ades);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        mem_issued = 1'b0; flush = 1'b0; in_valid = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_op(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [PREG_W-1:0] p);
        in_valid = 1'b1; in_wr = wr; in_size = sz; in_unsigned = uns;
        in_addr = a; in_wdata = wd; in_preg = p;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_req.size() + m_pend.size() + m_al.size()) > 0; i++) begin
            data_addr_ok = (m_req.size() > 0);
            data_data_ok = (m_pend.size() > 0);
            data_rdata   = $urandom;
            tick();
        end
    endtask

    initial begin
        int cmcnt;
        checks = 0; errors = 0; m_res = 0;
        e_cm_valid = 0; e_cm_preg = '0; e_cm_data = '0; e_adel = 0; e_ades = 0;
        resetn = 1'b0; mem_issued = 0; flush = 0; in_valid = 0; in_wr = 0; in_size = 0;
        in_unsigned = 0; in_addr = 0; in_wdata = 0; in_preg = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        @(negedge clk);
        tick(); tick();
        chk("rst_wait_mem", wait_mem, 0);
        chk("rst_data_req", data_req, 0);
        chk("rst_data_addr", data_addr, 0);
        chk("rst_data_wdata", data_wdata, 0);
        chk("rst_cm_valid", cm_valid, 0);
        chk("rst_cm_data", cm_data, 0);
        chk("rst_cm_flags", {cm_adel, cm_ades}, 0);
        resetn = 1'b1;

        // signed byte load from the top lane
        mem_issued = 1; tick();
        set_op(0, 2'd0, 0, 32'h0000_1003, 32'h0, 6'd5); tick();
        chk("lb_addr", data_addr, 32'h0000_1003);
        data_addr_ok = 1; tick();
        tick(); tick();
        data_data_ok = 1; data_rdata = 32'h8011_2233; tick();
        chk("lb_cm_valid", cm_valid, 1);
        chk("lb_cm_data", cm_data, 32'hFFFF_FF80);
        chk("lb_cm_preg", cm_preg, 6'd5);
        tick();
        chk("lb_cm_pulse", cm_valid, 0);

        // credit exhaustion and release
        for (int i = 0; i < 4; i++) begin
            chk("fill_wait_pre", wait_mem, 0);
            mem_issued = 1; tick();
        end
        chk("full_wait", wait_mem, 1);
        for (int i = 0; i < 4; i++) begin
            set_op(0, 2'd2, 0, 32'h100 + 4 * i, 0, PREG_W'(10 + i)); tick();
        end
        chk("full_wait_q", wait_mem, 1);
        data_addr_ok = 1; tick();
        chk("full_wait_pend", wait_mem, 1);
        data_data_ok = 1; data_rdata = 32'hCAFE_0001; tick();
        chk("dok_frees", wait_mem, 0);
        mem_issued = 1; tick();
        chk("refull_wait", wait_mem, 1);
        data_addr_ok = 1; tick();
        mem_issued = 1; data_data_ok = 1; data_rdata = 32'h1357_9BDF; tick();
        chk("net_full_wait", wait_mem, 1);
        set_op(0, 2'd1, 1, 32'h0000_0202, 0, 6'd20); tick();
        set_op(0, 2'd0, 1, 32'h0000_0301, 0, 6'd21); tick();
        drain();
        chk("drained_wait", wait_mem, 0);

        // store half replication
        mem_issued = 1; tick();
        set_op(1, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD, 6'd22); tick();
        chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
        chk("sh_size", data_size, 2'd1);
        chk("sh_wr", data_wr, 1);
        data_addr_ok = 1; tick();
        data_data_ok = 1; data_rdata = 32'hFFFF_FFFF; tick();
        chk("sh_cm_valid", cm_valid, 1);
        chk("sh_cm_data", cm_data, 0);

        // flush with one unaccepted request on the bus and two pending
        for (int i = 0; i < 3; i++) begin mem_issued = 1; tick(); end
        set_op(0, 2'd2, 0, 32'h400, 0, 6'd30); tick();
        set_op(1, 2'd2, 0, 32'h404, 32'h55, 6'd31); data_addr_ok = 1; tick();
        set_op(0, 2'd0, 0, 32'h409, 0, 6'd32); data_addr_ok = 1; tick();
        chk("fl_pre_req", data_req, 1);
        flush = 1; tick();
        chk("fl_head_stays", data_req, 1);
        chk("fl_head_addr", data_addr, 32'h409);
        tick();
        data_addr_ok = 1; tick();
        chk("fl_bus_idle", data_req, 0);
        cmcnt = 0;
        for (int i = 0; i < 3; i++) begin
            data_data_ok = 1; data_rdata = $urandom; tick();
            cmcnt += int'(cm_valid);
        end
        chk("fl_no_cm", cmcnt, 0);
        for (int i = 0; i < 3; i++) begin mem_issued = 1; tick(); end
        chk("fl_free3_wait", wait_mem, 0);
        mem_issued = 1; tick();
        chk("fl_free4_wait", wait_mem, 1);
        flush = 1; tick();
        chk("fl_clear_wait", wait_mem, 0);

`ifdef MEM_REQ_CTRL_ADDR_CHECK_EN
        mem_issued = 1; tick();
        set_op(0, 2'd2, 0, 32'h0000_1002, 0, 6'd33); tick();
        chk("al_no_req", data_req, 0);
        chk("al_cm_valid", cm_valid, 1);
        chk("al_adel", cm_adel, 1);
        chk("al_preg", cm_preg, 6'd33);
`endif

        // randomized traffic with one mid-run reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 63) == 0) flush = 1;
            if (m_free() > 0 && $urandom_range(0, 1) == 1) mem_issued = 1;
            if (m_res > 0 && $urandom_range(0, 1) == 1)
                set_op($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 1),
                       $urandom, $urandom, PREG_W'($urandom));
            if (m_req.size() > 0 && $urandom_range(0, 1) == 1) data_addr_ok = 1;
            if (m_pend.size() > 0 && $urandom_range(0, 2) != 0) data_data_ok = 1;
            data_rdata = $urandom;
            if (cyc == 1500) begin
                resetn = 0; flush = 0; mem_issued = 0; in_valid = 0;
                data_addr_ok = 0; data_data_ok = 0;
            end
            tick();
            resetn = 1;
        end
        drain();
        flush = 1; tick();
        chk("end_wait", wait_mem, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
